// File: rtl/uart_rx_deserializer_if.sv
// Parallel result bus of the UART Rx framing stage: received word plus
// per-frame status pulses. Master side is the deserializer.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 framing_error;
  logic                 parity_error;

  modport master (
    output data_out,
    output data_valid,
    output framing_error,
    output parity_error
  );

  modport slave (
    input data_out,
    input data_valid,
    input framing_error,
    input parity_error
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART Rx framing stage: line synchronizer, start-edge detect, strobe-driven
// start/data/stop checks. Define RX_PARITY_EN to add an even-parity bit check.
module uart_rx_deserializer #(
  parameter int DATA_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    serial_in,
  input  logic                    sampling_strobe,
  output logic                    start_detected,
  output logic                    busy,
  uart_rx_deserializer_if.master  rx
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic                 fall;

  assign fall = rx_prev & ~rx_sync;
  assign busy = (state != IDLE);

`ifdef RX_PARITY_EN
  logic par_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bad         <= 1'b0;
      rx.parity_error <= 1'b0;
    end else begin
      rx.parity_error <= 1'b0;
      // Even parity over data + parity bit; the verdict is held until the
      // stop strobe so it is reported alongside the frame outcome.
      if (state == PARITY && sampling_strobe)
        par_bad <= ^{shreg, rx_sync};
      if (state == STOP && sampling_strobe)
        rx.parity_error <= par_bad;
    end
  end
`else
  assign rx.parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta          <= 1'b1;
      rx_sync          <= 1'b1;
      rx_prev          <= 1'b1;
      state            <= IDLE;
      shreg            <= '0;
      bit_cnt          <= '0;
      start_detected   <= 1'b0;
      rx.data_out      <= '0;
      rx.data_valid    <= 1'b0;
      rx.framing_error <= 1'b0;
    end else begin
      rx_meta          <= serial_in;
      rx_sync          <= rx_meta;
      rx_prev          <= rx_sync;
      start_detected   <= 1'b0;
      rx.data_valid    <= 1'b0;
      rx.framing_error <= 1'b0;

      case (state)
        IDLE: begin
          // Strobes are ignored here: the generator free-runs between frames.
          if (fall) begin
            start_detected <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          if (sampling_strobe) begin
            if (!rx_sync) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state   <= IDLE;
            end
          end
        end
        DATA: begin
          if (sampling_strobe) begin
            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (sampling_strobe)
            state <= STOP;
        end
`endif
        STOP: begin
          if (sampling_strobe) begin
            if (rx_sync) begin
              rx.data_out   <= shreg;
              rx.data_valid <= 1'b1;
            end else begin
              rx.framing_error <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives the serial line with a
// re-phasing mid-bit strobe model and checks frame outcomes and pulse timing.
module tb_uart_rx_deserializer;

  localparam int DATA_BITS = 8;
  localparam int CPB       = 8;

  logic clk             = 1'b0;
  logic reset_n         = 1'b0;
  logic serial_in       = 1'b1;
  logic sampling_strobe = 1'b0;
  logic start_detected;
  logic busy;

  uart_rx_deserializer_if #(.DATA_BITS(DATA_BITS)) rx_bus ();

  uart_rx_deserializer #(.DATA_BITS(DATA_BITS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .serial_in       (serial_in),
    .sampling_strobe (sampling_strobe),
    .start_detected  (start_detected),
    .busy            (busy),
    .rx              (rx_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and output monitor (sampled on the falling edge).
  int cyc = 0;
  int n_start = 0, n_valid = 0, n_ferr = 0, n_perr = 0;
  int start_cyc = 0, valid_cyc = 0, busy_fall_cyc = 0, fall_cyc = 0;
  int long_pulse = 0, overlap = 0, perr_with_dv = 0;
  logic [7:0] vals[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic p_busy, p_dv, p_fe, p_sd;
    p_busy = 1'b0; p_dv = 1'b0; p_fe = 1'b0; p_sd = 1'b0;
    forever begin
      @(negedge clk);
      if (start_detected) begin n_start++; start_cyc = cyc; end
      if (rx_bus.data_valid) begin
        n_valid++;
        valid_cyc = cyc;
        vals.push_back(rx_bus.data_out);
      end
      if (rx_bus.framing_error) n_ferr++;
      if (rx_bus.parity_error) begin
        n_perr++;
        if (rx_bus.data_valid) perr_with_dv++;
      end
      if (p_busy && !busy) busy_fall_cyc = cyc;
      if ((rx_bus.data_valid && p_dv) || (rx_bus.framing_error && p_fe) || (start_detected && p_sd))
        long_pulse++;
      if (rx_bus.data_valid && rx_bus.framing_error) overlap++;
      p_busy = busy; p_dv = rx_bus.data_valid; p_fe = rx_bus.framing_error; p_sd = start_detected;
    end
  end

  // Strobe generator model: free-running, re-phased by start_detected.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (start_detected) ph = 0;
      else ph = (ph == CPB - 1) ? 0 : ph + 1;
      sampling_strobe = (ph == 3);
    end
  end

  // Called 1 time unit after a rising edge; returns likewise.
  task automatic drive_bit(input logic b, input int n);
    serial_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int idle);
    fall_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], CPB);
`ifdef RX_PARITY_EN
    drive_bit(par, CPB);
`else
    if (par) begin end
`endif
    drive_bit(stop, CPB);
    if (idle > 0) drive_bit(1'b1, idle);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start",  start_detected, 0);
    check("rst_data",   rx_bus.data_out, 0);
    check("rst_valid",  rx_bus.data_valid, 0);
    check("rst_ferr",   rx_bus.framing_error, 0);
    check("rst_perr",   rx_bus.parity_error, 0);
    check("rst_busy",   busy, 0);
    reset_n = 1'b1;
    drive_bit(1'b1, 5);

    // Good frame 0xA5 (4 ones -> even parity bit 0).
    send_frame(8'hA5, 1'b0, 1'b1, 6);
    check("a5_nstart",  n_start, 1);
    check("a5_latency", start_cyc - fall_cyc, 3);
    check("a5_nvalid",  n_valid, 1);
    check("a5_data",    rx_bus.data_out, 8'hA5);
    check("a5_ferr",    n_ferr, 0);
    check("a5_busyfall", busy_fall_cyc, valid_cyc);
    check("a5_busy",    busy, 0);

    // Two-clock low glitch: false start.
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 16);
    check("gl_nstart",  n_start, 2);
    check("gl_nvalid",  n_valid, 1);
    check("gl_ferr",    n_ferr, 0);
    check("gl_data",    rx_bus.data_out, 8'hA5);
    check("gl_busy",    busy, 0);

    // 0x3C with stop low, then good 0x81.
    send_frame(8'h3C, 1'b0, 1'b0, 16);
    check("fe_nferr",   n_ferr, 1);
    check("fe_nvalid",  n_valid, 1);
    check("fe_data",    rx_bus.data_out, 8'hA5);
    send_frame(8'h81, 1'b0, 1'b1, 6);
    check("81_nvalid",  n_valid, 2);
    check("81_data",    rx_bus.data_out, 8'h81);

    // Reset after the 4th data strobe of 0xFF.
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
    check("mid_busy",   busy, 1);
    reset_n = 1'b0;
    #1;
    check("mr_busy",    busy, 0);
    check("mr_data",    rx_bus.data_out, 0);
    check("mr_valid",   rx_bus.data_valid, 0);
    check("mr_start",   start_detected, 0);
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_bit(1'b1, CPB);
    check("mr_nvalid",  n_valid, 2);
    send_frame(8'h12, 1'b0, 1'b1, 6);
    check("12_nvalid",  n_valid, 3);
    check("12_data",    rx_bus.data_out, 8'h12);

    // Back-to-back 0x00 then 0xFF, single stop bit.
    send_frame(8'h00, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 6);
    check("b2b_nvalid", n_valid, 5);
    check("b2b_first",  vals[3], 8'h00);
    check("b2b_second", vals[4], 8'hFF);
    check("b2b_ferr",   n_ferr, 1);

`ifdef RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 6);
    check("p1_nvalid",  n_valid, 6);
    check("p1_data",    rx_bus.data_out, 8'h07);
    check("p1_nperr",   n_perr, 0);
    send_frame(8'h07, 1'b0, 1'b1, 6);
    check("p0_nvalid",  n_valid, 7);
    check("p0_nperr",   n_perr, 1);
    check("p0_with_dv", perr_with_dv, 1);
`else
    check("np_nperr",   n_perr, 0);
`endif

    check("pulse_width", long_pulse, 0);
    check("dv_fe_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
